// File: rtl/inst_buffer_mw.sv
// Multi-lane IF->ID instruction buffer: compacting circular FIFO
// with take-count dequeue and squash-time target lane skipping.
package inst_buffer_mw_pkg;
  localparam int XLEN = 32;

  typedef struct packed {
    logic            valid;
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc;
  } if_ib_packet_t;

  typedef struct packed {
    logic            valid;
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc;
  } ib_id_packet_t;
endpackage

module inst_buffer_mw
  import inst_buffer_mw_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2,
  parameter int CAP     = DEPTH * FETCH_W,
  parameter int CW      = $clog2(CAP + 1),
  parameter int TW      = $clog2(ISSUE_W + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            squash,
  input  logic [XLEN-1:0] branch_target,
  input  if_ib_packet_t   if_ib_packet [0:FETCH_W-1],
  output logic            if_ready,
  output ib_id_packet_t   ib_id_packet [0:ISSUE_W-1],
  input  logic [TW-1:0]   id_take,
  output logic [CW-1:0]   count,
  output logic            empty,
  output logic            full
);

  localparam int PW = $clog2(CAP);
  localparam int SW = $clog2(FETCH_W) + 1;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc;
  } slot_t;

  slot_t            mem_q [CAP];
  logic [PW-1:0]    h_q, h_d;
  logic [PW-1:0]    t_q, t_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]    skip_q, skip_d;

  logic [CW-1:0]    n_w, n_we, n_r;
  logic [PW-1:0]    wpos [FETCH_W];
  logic [FETCH_W-1:0] lane_ok;
  logic             any_v;
  logic             wr_en;
  logic             unused_bt;

  assign unused_bt = ^branch_target;

  assign if_ready = cnt_q <= CW'(CAP - FETCH_W);
  assign count    = cnt_q;
  assign empty    = cnt_q == '0;
  assign full     = cnt_q == CW'(CAP);

  always_comb begin
    any_v = 1'b0;
    n_w   = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      any_v      = any_v | if_ib_packet[i].valid;
      lane_ok[i] = if_ib_packet[i].valid && (SW'(i) >= skip_q);
      wpos[i]    = t_q + n_w[PW-1:0];
      if (lane_ok[i]) n_w = n_w + CW'(1);
    end
    wr_en = if_ready && any_v && !squash;
    n_we  = wr_en ? n_w : '0;

    // take is clipped to what is both presented and present
    n_r = CW'(id_take);
    if (n_r > cnt_q) n_r = cnt_q;
    if (n_r > CW'(ISSUE_W)) n_r = CW'(ISSUE_W);

    h_d    = h_q;
    t_d    = t_q;
    cnt_d  = cnt_q;
    skip_d = skip_q;
    if (squash) begin
      h_d    = '0;
      t_d    = '0;
      cnt_d  = '0;
      skip_d = SW'((branch_target >> 2) & XLEN'(FETCH_W - 1));
    end else begin
      h_d   = h_q + n_r[PW-1:0];
      t_d   = t_q + n_we[PW-1:0];
      cnt_d = cnt_q + n_we - n_r;
      if (if_ready && any_v) skip_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      h_q    <= '0;
      t_q    <= '0;
      cnt_q  <= '0;
      skip_q <= '0;
    end else begin
      h_q    <= h_d;
      t_q    <= t_d;
      cnt_q  <= cnt_d;
      skip_q <= skip_d;
    end
  end

  // payload storage needs no reset; validity comes from cnt_q
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int i = 0; i < FETCH_W; i++) begin
        if (lane_ok[i]) begin
          mem_q[wpos[i]] <= '{inst: if_ib_packet[i].inst,
                              pc:   if_ib_packet[i].pc,
                              npc:  if_ib_packet[i].npc};
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < ISSUE_W; k++) begin
      ib_id_packet[k].valid = CW'(k) < cnt_q;
      ib_id_packet[k].inst  = mem_q[h_q + PW'(k)].inst;
      ib_id_packet[k].pc    = mem_q[h_q + PW'(k)].pc;
      ib_id_packet[k].npc   = mem_q[h_q + PW'(k)].npc;
    end
  end

endmodule

// File: tb/tb_inst_buffer_mw.sv
// Scoreboard bench for inst_buffer_mw against a queue-based
// reference model, with directed and random stimulus.
module tb_inst_buffer_mw;
  import inst_buffer_mw_pkg::*;

  localparam int DEPTH = 4;
  localparam int FW    = 2;
  localparam int IW    = 4;
  localparam int CAP   = DEPTH * FW;
  localparam int CW    = $clog2(CAP + 1);
  localparam int TW    = $clog2(IW + 1);

  logic            clk = 1'b0;
  logic            rst_n;
  logic            squash;
  logic [XLEN-1:0] bt;
  if_ib_packet_t   inp  [0:FW-1];
  ib_id_packet_t   outp [0:IW-1];
  logic            if_ready;
  logic [TW-1:0]   take;
  logic [CW-1:0]   count;
  logic            empty, full;

  always #5 clk = ~clk;

  inst_buffer_mw #(
    .DEPTH(DEPTH), .FETCH_W(FW), .ISSUE_W(IW)
  ) dut (
    .clock(clk), .reset(rst_n), .squash(squash),
    .branch_target(bt), .if_ib_packet(inp),
    .if_ready(if_ready), .ib_id_packet(outp),
    .id_take(take), .count(count),
    .empty(empty), .full(full)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  typedef struct {
    int                    cnt;
    bit                    rdy, emp, ful;
    logic [IW-1:0]         v;
    logic [IW-1:0][31:0]   pc;
    logic [IW-1:0][31:0]   inst;
  } snap_t;

  ent_t  mq[$];
  snap_t exp_q[$];
  snap_t e;
  int    mskip = 0;
  int    checks = 0;
  int    errors = 0;
  logic [31:0] pcn = 32'h1000;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic snap_t snap();
    snap_t s;
    s.cnt = mq.size();
    s.rdy = mq.size() <= CAP - FW;
    s.emp = mq.size() == 0;
    s.ful = mq.size() == CAP;
    s.v = '0; s.pc = '0; s.inst = '0;
    for (int k = 0; k < IW; k++) begin
      if (k < mq.size()) begin
        s.v[k]    = 1'b1;
        s.pc[k]   = mq[k].pc;
        s.inst[k] = mq[k].inst;
      end
    end
    return s;
  endfunction

  // monitor: one expected snapshot per clock, compared mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("count", 32'(count), e.cnt);
      chk("if_ready", 32'(if_ready), 32'(e.rdy));
      chk("empty", 32'(empty), 32'(e.emp));
      chk("full", 32'(full), 32'(e.ful));
      for (int k = 0; k < IW; k++) begin
        chk($sformatf("valid%0d", k), 32'(outp[k].valid), 32'(e.v[k]));
        if (e.v[k]) begin
          chk($sformatf("pc%0d", k), outp[k].pc, e.pc[k]);
          chk($sformatf("inst%0d", k), outp[k].inst, e.inst[k]);
          chk($sformatf("npc%0d", k), outp[k].npc, e.pc[k] + 32'd4);
        end
      end
    end
  end

  task automatic drive(bit sq, logic [31:0] t, logic [FW-1:0] vm,
                       logic [31:0] base, int tk);
    snap_t s;
    int    n, nr;
    squash = sq;
    bt     = t;
    take   = TW'(tk);
    for (int i = 0; i < FW; i++) begin
      inp[i].valid = vm[i];
      inp[i].pc    = base + 32'(4 * i);
      inp[i].npc   = base + 32'(4 * i + 4);
      inp[i].inst  = $urandom;
    end
    if (sq) begin
      mq.delete();
      mskip = int'((t >> 2) % FW);
    end else begin
      n  = mq.size();
      nr = tk;
      if (nr > n) nr = n;
      if (nr > IW) nr = IW;
      repeat (nr) void'(mq.pop_front());
      if (n <= CAP - FW && vm != '0) begin
        for (int i = 0; i < FW; i++)
          if (vm[i] && i >= mskip)
            mq.push_back('{inp[i].inst, inp[i].pc});
        mskip = 0;
      end
    end
    s = snap();
    @(posedge clk);
    exp_q.push_back(s);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, '0, 32'h0, 0);
  endtask

  initial begin
    rst_n  = 1'b0;
    squash = 1'b0;
    bt     = '0;
    take   = '0;
    for (int i = 0; i < FW; i++) inp[i] = '0;
    repeat (2) @(posedge clk);
    exp_q.push_back(snap());
    #1 rst_n = 1'b1;

    // first group, then compaction of a lone lane-1 instruction
    drive(1'b0, 0, 2'b11, 32'h0, 0);
    drive(1'b0, 0, 2'b00, 32'h0, 2);
    drive(1'b0, 0, 2'b10, 32'h10, 0);
    drive(1'b0, 0, 2'b00, 32'h0, 1);

    // partial takes, then take 3 with a concurrent 2-lane write
    drive(1'b0, 0, 2'b11, 32'h20, 0);
    drive(1'b0, 0, 2'b11, 32'h28, 0);
    drive(1'b0, 0, 2'b00, 32'h0, 1);
    drive(1'b0, 0, 2'b11, 32'h30, 3);
    drive(1'b0, 0, 2'b00, 32'h0, 7);

    // fill to full, drop while not ready, then wrap
    drive(1'b0, 0, 2'b11, 32'h40, 0);
    drive(1'b0, 0, 2'b11, 32'h48, 0);
    drive(1'b0, 0, 2'b11, 32'h50, 0);
    drive(1'b0, 0, 2'b11, 32'h58, 0);
    drive(1'b0, 0, 2'b00, 32'h0, 1);
    drive(1'b0, 0, 2'b11, 32'h60, 0);
    drive(1'b0, 0, 2'b00, 32'h0, 3);
    drive(1'b0, 0, 2'b11, 32'h68, 0);
    drive(1'b0, 0, 2'b11, 32'h70, 2);
    drive(1'b0, 0, 2'b00, 32'h0, 4);
    drive(1'b0, 0, 2'b00, 32'h0, 4);

    // squash with write and take pending, then skip lane 0
    drive(1'b0, 0, 2'b11, 32'h80, 0);
    drive(1'b1, 32'h104, 2'b11, 32'h200, 2);
    drive(1'b0, 0, 2'b11, 32'h100, 0);
    drive(1'b0, 0, 2'b11, 32'h108, 0);
    drive(1'b0, 0, 2'b00, 32'h0, 4);

    for (int it = 0; it < 400; it++) begin
      drive($urandom_range(0, 24) == 0, $urandom,
            FW'($urandom), pcn, $urandom_range(0, 5));
      pcn += 32'(4 * FW);
    end

    // asynchronous reset between clock edges
    drive(1'b0, 0, 2'b11, 32'h300, 0);
    drive(1'b0, 0, 2'b11, 32'h308, 0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_count", 32'(count), 32'd0);
    chk("async_empty", 32'(empty), 32'd1);
    chk("async_ready", 32'(if_ready), 32'd1);
    chk("async_valid0", 32'(outp[0].valid), 32'd0);
    mq.delete();
    mskip = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1'b0, 0, 2'b01, 32'h400, 0);
    idle();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
